// File: rtl/boot_pkg.sv
// Shared state encoding and default timing for the chipset boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    OFF,
    HOLD,
    COPY_RD,
    COPY_WR,
    RUN
  } boot_state_t;

  localparam int DEFAULT_ADDR_WIDTH        = 16;
  localparam int DEFAULT_DATA_WIDTH        = 8;
  localparam int DEFAULT_ROM_WORDS         = 256;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 4;
  localparam int DEFAULT_RESET_HOLD_CYCLES = 8;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boot_sequencer_debouncer.sv
// Two-flop synchronizer and debounce counter for the raw reset button.
module button_debouncer
  import boot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic press_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // The counter saturates one short of the target; the current high sample completes the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= button_raw;
      sync_q2 <= sync_q1;
      if (!sync_q2) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press_level = sync_q2 && (cnt == CNT_LAST);

endmodule

// File: rtl/boot_sequencer.sv
// Power-up / reset-button sequencer: holds the CPU in reset, copies ROM into RAM, then runs from RAM.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int ROM_WORDS         = DEFAULT_ROM_WORDS,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_button,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  cpu_reset,
  output logic                  is_powered_on,
  output logic                  flag_execute_from_ram,
  output logic                  boot_done
);

  localparam int HW = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] IDX_LAST  = (ADDR_WIDTH + 1)'(ROM_WORDS - 1);

  boot_state_t           state;
  logic [HW-1:0]         hold_cnt;
  logic [ADDR_WIDTH:0]   copy_idx;
  logic [ADDR_WIDTH:0]   next_idx;
  logic                  last_word;
  logic                  press_level;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .button_raw (reset_button),
    .press_level(press_level)
  );

  assign next_idx  = copy_idx + 1'b1;
  assign last_word = (copy_idx == IDX_LAST);

  // ROM data for word i arrives during COPY_WR, so the write lands in the cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= OFF;
      hold_cnt              <= '0;
      copy_idx              <= '0;
      rom_addr              <= '0;
      ram_addr              <= '0;
      ram_wdata             <= '0;
      ram_we                <= 1'b0;
      cpu_reset             <= 1'b1;
      is_powered_on         <= 1'b0;
      flag_execute_from_ram <= 1'b0;
      boot_done             <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      boot_done <= 1'b0;
      case (state)
        OFF: begin
          state         <= HOLD;
          is_powered_on <= 1'b1;
          hold_cnt      <= '0;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= COPY_RD;
            hold_cnt <= '0;
            copy_idx <= '0;
            rom_addr <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        COPY_RD: begin
          state <= COPY_WR;
        end
        COPY_WR: begin
          ram_addr  <= copy_idx[ADDR_WIDTH-1:0];
          ram_wdata <= rom_data;
          ram_we    <= 1'b1;
          if (last_word) begin
            state                 <= RUN;
            cpu_reset             <= 1'b0;
            flag_execute_from_ram <= 1'b1;
            boot_done             <= 1'b1;
          end else begin
            copy_idx <= next_idx;
            rom_addr <= next_idx[ADDR_WIDTH-1:0];
            state    <= COPY_RD;
          end
        end
        RUN: begin
        end
        default: begin
          state <= OFF;
        end
      endcase

      // A recognized press restarts the whole boot; only the final word's write is allowed to complete.
      if (press_level && (state != OFF)) begin
        state                 <= HOLD;
        hold_cnt              <= '0;
        copy_idx              <= '0;
        rom_addr              <= '0;
        cpu_reset             <= 1'b1;
        flag_execute_from_ram <= 1'b0;
        boot_done             <= 1'b0;
        if (!((state == COPY_WR) && last_word)) begin
          ram_we <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer with a 4-word ROM image.
module tb_boot_sequencer;

  localparam int ADDR_WIDTH        = 16;
  localparam int DATA_WIDTH        = 8;
  localparam int ROM_WORDS         = 4;
  localparam int DEBOUNCE_CYCLES   = 3;
  localparam int RESET_HOLD_CYCLES = 4;

  logic                  clk;
  logic                  reset;
  logic                  reset_button;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic                  cpu_reset;
  logic                  is_powered_on;
  logic                  flag_execute_from_ram;
  logic                  boot_done;

  logic [DATA_WIDTH-1:0] rom_mem  [ROM_WORDS] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [DATA_WIDTH-1:0] exp_data [ROM_WORDS] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  int checks   = 0;
  int failures = 0;

  boot_sequencer #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .DATA_WIDTH       (DATA_WIDTH),
    .ROM_WORDS        (ROM_WORDS),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .reset_button         (reset_button),
    .rom_addr             (rom_addr),
    .rom_data             (rom_data),
    .ram_addr             (ram_addr),
    .ram_wdata            (ram_wdata),
    .ram_we               (ram_we),
    .cpu_reset            (cpu_reset),
    .is_powered_on        (is_powered_on),
    .flag_execute_from_ram(flag_execute_from_ram),
    .boot_done            (boot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr[1:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic btn);
    reset        = rst;
    reset_button = btn;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tick-by-tick check of a full copy: first write visible at t_first, RUN entered with the last write.
  task automatic runCopyCheck(input string tag, input int t_first);
    int   t_run;
    int   w;
    logic exp_we;
    t_run = t_first + 2 * (ROM_WORDS - 1);
    for (int t = 1; t <= t_run + 1; t++) begin
      tick(1);
      exp_we = (t >= t_first) && (t <= t_run) && (((t - t_first) % 2) == 0);
      checkOutput($sformatf("%s_we_t%0d", tag, t), 32'(ram_we), 32'(exp_we));
      if (exp_we) begin
        w = (t - t_first) / 2;
        checkOutput($sformatf("%s_addr_t%0d", tag, t), 32'(ram_addr), 32'(w));
        checkOutput($sformatf("%s_data_t%0d", tag, t), 32'(ram_wdata), 32'(exp_data[w]));
      end
      checkOutput($sformatf("%s_flag_t%0d", tag, t), 32'(flag_execute_from_ram), 32'(t >= t_run));
      checkOutput($sformatf("%s_done_t%0d", tag, t), 32'(boot_done), 32'(t == t_run));
      checkOutput($sformatf("%s_cpurst_t%0d", tag, t), 32'(cpu_reset), 32'(t < t_run));
      checkOutput($sformatf("%s_pwr_t%0d", tag, t), 32'(is_powered_on), 32'd1);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0);
    tick(3);
    $display("[TB] reset values");
    checkOutput("rst_pwr", 32'(is_powered_on), 32'd0);
    checkOutput("rst_cpurst", 32'(cpu_reset), 32'd1);
    checkOutput("rst_flag", 32'(flag_execute_from_ram), 32'd0);
    checkOutput("rst_we", 32'(ram_we), 32'd0);
    checkOutput("rst_done", 32'(boot_done), 32'd0);
    checkOutput("rst_romaddr", 32'(rom_addr), 32'd0);

    $display("[TB] power-up boot");
    applyStimulus(1'b0, 1'b0);
    runCopyCheck("boot", 7);

    $display("[TB] two-cycle glitch in RUN");
    applyStimulus(1'b0, 1'b1);
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      checkOutput($sformatf("glitch_flag_t%0d", t), 32'(flag_execute_from_ram), 32'd1);
      checkOutput($sformatf("glitch_cpurst_t%0d", t), 32'(cpu_reset), 32'd0);
      checkOutput($sformatf("glitch_we_t%0d", t), 32'(ram_we), 32'd0);
      if (t == 2) applyStimulus(1'b0, 1'b0);
    end

    $display("[TB] press in RUN");
    applyStimulus(1'b0, 1'b1);
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      checkOutput($sformatf("press_flag_t%0d", t), 32'(flag_execute_from_ram), 32'(t < 5));
      checkOutput($sformatf("press_cpurst_t%0d", t), 32'(cpu_reset), 32'(t >= 5));
      checkOutput($sformatf("press_we_t%0d", t), 32'(ram_we), 32'd0);
      checkOutput($sformatf("press_pwr_t%0d", t), 32'(is_powered_on), 32'd1);
    end
    applyStimulus(1'b0, 1'b0);
    runCopyCheck("rerun", 8);

    $display("[TB] press during word 1 copy");
    applyStimulus(1'b1, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      checkOutput($sformatf("mid_we_t%0d", t), 32'(ram_we), 32'(t == 7));
      if (t == 7) begin
        checkOutput("mid_addr_t7", 32'(ram_addr), 32'd0);
        checkOutput("mid_data_t7", 32'(ram_wdata), 32'hA1);
      end
      if (t == 4) applyStimulus(1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0);
    runCopyCheck("midcopy", 8);

    $display("[TB] reset during COPY_WR");
    applyStimulus(1'b1, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0);
    tick(6);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("rcopy_pwr", 32'(is_powered_on), 32'd0);
    checkOutput("rcopy_we", 32'(ram_we), 32'd0);
    checkOutput("rcopy_cpurst", 32'(cpu_reset), 32'd1);
    checkOutput("rcopy_flag", 32'(flag_execute_from_ram), 32'd0);
    checkOutput("rcopy_done", 32'(boot_done), 32'd0);
    checkOutput("rcopy_romaddr", 32'(rom_addr), 32'd0);
    checkOutput("rcopy_ramaddr", 32'(ram_addr), 32'd0);
    checkOutput("rcopy_wdata", 32'(ram_wdata), 32'd0);

    $display("[TB] button held across reset release");
    applyStimulus(1'b1, 1'b1);
    tick(3);
    applyStimulus(1'b0, 1'b1);
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      checkOutput($sformatf("held_we_t%0d", t), 32'(ram_we), 32'd0);
      checkOutput($sformatf("held_pwr_t%0d", t), 32'(is_powered_on), 32'd1);
      checkOutput($sformatf("held_cpurst_t%0d", t), 32'(cpu_reset), 32'd1);
      checkOutput($sformatf("held_flag_t%0d", t), 32'(flag_execute_from_ram), 32'd0);
    end
    applyStimulus(1'b0, 1'b0);
    runCopyCheck("held", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Clocked controller that sequences chipset power-up and the reset button: holds the CPU in reset, copies the boot image from ROM into RAM, then switches execution to RAM.
- Sits inside the chipset between the reset button, the ROM/RAM ports and the CPU.
- Drives is_powered_on and flag_execute_from_ram.

Parameters:
- ADDR_WIDTH, 16, ROM/RAM address width (matches pc width).
- DATA_WIDTH, 8, memory word width.
- ROM_WORDS, 256, number of words copied, range 1..2^ADDR_WIDTH.
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high samples that count as a press, ≥1.
- RESET_HOLD_CYCLES, 8, minimum cycles in HOLD with button low before copy starts, ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- reset_button  in  1  raw asynchronous button level
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH  ROM data, valid one cycle after rom_addr
- ram_addr  out  ADDR_WIDTH  RAM write address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_we  out  1  RAM write strobe, one word per asserted cycle
- cpu_reset  out  1  holds CPU/pc in reset
- is_powered_on  out  1  chipset powered
- flag_execute_from_ram  out  1  CPU fetches from RAM
- boot_done  out  1  pulse, one cycle on entry to RUN

Behaviour:
- One clock; reset is synchronous and active-high. All outputs registered.
- Values while reset is high: state OFF, cpu_reset=1, is_powered_on=0, flag_execute_from_ram=0, ram_we=0, boot_done=0, rom_addr=0, ram_addr=0, ram_wdata=0, counters=0, synchronizer=0.
- Button path:
  - 2-flop synchronizer, then a debounce counter.
  - Press recognized when DEBOUNCE_CYCLES consecutive synchronized samples are high.
  - Any low sample clears the counter; shorter glitches are ignored.
  - Press latency from the raw rising edge is 2+DEBOUNCE_CYCLES cycles.
- States:
  - OFF -> HOLD unconditionally on the next edge.
  - HOLD:
    - Hold counter counts cycles with the debounced button low.
    - Counter restarts while the button is high.
    - At RESET_HOLD_CYCLES -> COPY_RD with rom_addr=0.
  - COPY_RD: rom_addr=i, ram_we=0 -> COPY_WR.
  - COPY_WR:
    - ram_addr=i, ram_wdata=rom_data, ram_we=1.
    - If i==ROM_WORDS-1 -> RUN, else i+1 -> COPY_RD.
  - RUN: cpu_reset=0, flag_execute_from_ram=1, boot_done=1 for the entry cycle only. Stays in RUN.
- Cycles and latency:
  - Each word takes 2 cycles.
  - Copy index width is ADDR_WIDTH+1 so ROM_WORDS=2^ADDR_WIDTH terminates without wrap.
  - Boot latency from reset deassert to first RUN cycle: 1+RESET_HOLD_CYCLES+2*ROM_WORDS.
- Output levels by state:
  - is_powered_on=1 in every state except OFF.
  - cpu_reset=1 in every state except RUN.
  - flag_execute_from_ram=0 except in RUN.
- Recognized press in any state other than OFF (including mid-copy and RUN) -> HOLD on the next edge:
  - ram_we=0 and flag=0 that cycle, cpu_reset=1.
  - Copy index cleared; the full copy restarts after the next HOLD.
- Simultaneous events:
  - reset overrides a press.
  - A press in the same cycle as the last COPY_WR goes to HOLD, not RUN; that final write still occurs.
- Holding the button indefinitely keeps the block in HOLD with is_powered_on=1.

Decomposition:
- Shared package/include boot_pkg: state encoding constants (OFF, HOLD, COPY_RD, COPY_WR, RUN) and the default timing constants.
- One sub-module: button_debouncer (synchronizer plus debounce counter, output press_level).
- The FSM and copy engine stay in boot_sequencer.

Test Plan:
- Bench configuration: ROM_WORDS=4, DEBOUNCE_CYCLES=3, RESET_HOLD_CYCLES=4, ROM contents {0xA1, 0xB2, 0xC3, 0xD4}.
- Power-up: release reset at cycle 0 -> is_powered_on=1 from cycle 1; RAM writes 0:A1, 1:B2, 2:C3, 3:D4, each ram_we exactly one cycle; RUN, flag_execute_from_ram=1, cpu_reset=0 and a single boot_done pulse at cycle 13.
- Glitch: 2-cycle button pulse during RUN -> no change, flag stays 1.
- Press in RUN: button high 10 cycles -> within 5 cycles of the rise, flag=0 and cpu_reset=1. After release: 4 hold cycles, the 4 words rewritten, RUN again.
- Mid-copy press: press while writing word 1 -> ram_we=0 from recognition; after release the copy restarts at address 0; no write to address 2 before the restart.
- Reset mid-copy: assert reset during COPY_WR -> next cycle all outputs equal the reset values (is_powered_on=0, ram_we=0).
- Button held across reset release -> remains in HOLD, no RAM writes until release plus 4 cycles.
